// File: rtl/rx_state_machine.sv
// rx_state_machine: UART receive control FSM that detects and confirms a start bit, then enables the datapath until the frame is done.
module rx_state_machine (
    input  logic clk,
    input  logic reset,
    input  logic Rx,
    input  logic Btu,
    input  logic Done,
    output logic DoIt,
    output logic Start
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        START   = 2'b01,
        RECEIVE = 2'b10,
        ILLEGAL = 2'b11
    } state_t;
    state_t state, nxt;
    // Rx high in START beats Btu so a glitch never reaches RECEIVE
    always_comb
        nxt = (state == IDLE)    ? (Rx ? IDLE : START) :
              (state == START)   ? (Rx ? IDLE : (Btu ? RECEIVE : START)) :
              (state == RECEIVE) ? (Done ? IDLE : RECEIVE) : IDLE;
    // Outputs are registered from the next state so they track the state register exactly
    always_ff @(posedge clk)
        if (reset) begin
            state <= IDLE;
            Start <= 1'b0;
            DoIt  <= 1'b0;
        end else begin
            state <= nxt;
            Start <= nxt == START;
            DoIt  <= nxt == START || nxt == RECEIVE;
        end
endmodule

// File: tb/tb_rx_state_machine.sv
// tb_rx_state_machine: directed checks of the receive control FSM outputs, compared as {Start, DoIt}.
module tb_rx_state_machine;
    logic clk = 1'b0;
    logic reset, Rx, Btu, Done;
    logic DoIt, Start;
    int total = 0;
    int bad = 0;
    rx_state_machine dut (
        .clk(clk), .reset(reset), .Rx(Rx), .Btu(Btu), .Done(Done),
        .DoIt(DoIt), .Start(Start)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: {Start,DoIt} got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        reset = 1'b1; Rx = 1'b0; Btu = 1'b0; Done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("reset_hold", {Start, DoIt}, 2'b00);
        end
        reset = 1'b0; Rx = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick;
            chk("idle_rx_high", {Start, DoIt}, 2'b00);
        end
        Rx = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick;
            chk("start_detect", {Start, DoIt}, 2'b11);
        end
        Btu = 1'b1;
        tick;
        chk("start_confirm", {Start, DoIt}, 2'b01);
        for (int i = 0; i < 60; i++) begin
            Rx = i[0]; Btu = i[1];
            tick;
            chk("receive_hold", {Start, DoIt}, 2'b01);
        end
        Rx = 1'b0; Btu = 1'b0; Done = 1'b1;
        tick;
        chk("frame_end", {Start, DoIt}, 2'b00);
        Done = 1'b0;
        tick;
        chk("back_to_back", {Start, DoIt}, 2'b11);
        Rx = 1'b1;
        tick;
        chk("false_start", {Start, DoIt}, 2'b00);
        Rx = 1'b0;
        tick;
        chk("restart", {Start, DoIt}, 2'b11);
        Rx = 1'b1; Btu = 1'b1;
        tick;
        chk("false_start_btu", {Start, DoIt}, 2'b00);
        Done = 1'b1;
        tick;
        chk("idle_ignores_btu_done", {Start, DoIt}, 2'b00);
        Rx = 1'b0; Btu = 1'b0;
        tick;
        chk("start_ignores_done", {Start, DoIt}, 2'b11);
        tick;
        chk("start_ignores_done2", {Start, DoIt}, 2'b11);
        Done = 1'b0; Btu = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("btu_held", {Start, DoIt}, 2'b01);
        end
        Btu = 1'b0; reset = 1'b1;
        tick;
        chk("reset_mid_frame", {Start, DoIt}, 2'b00);
        reset = 1'b0;
        tick;
        chk("after_reset_start", {Start, DoIt}, 2'b11);
        Btu = 1'b1;
        tick;
        chk("confirm2", {Start, DoIt}, 2'b01);
        Btu = 1'b0; Rx = 1'b1; Done = 1'b1;
        tick;
        chk("done_held", {Start, DoIt}, 2'b00);
        tick;
        chk("done_held2", {Start, DoIt}, 2'b00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rx_state_machine.md
# rx_state_machine

Control state machine for the UART receiver. It watches the serial input `Rx` for a falling edge that marks a start bit and confirms the start bit at mid-bit time. It then holds the receive datapath enabled until the bit counter reports completion. It sits beside the receive datapath (bit-time counter, bit counter, shift register), which supplies `Btu` and `Done` and consumes `DoIt` and `Start`.

## Interface
- No parameters.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `Rx`  input  1  serial receive line; idles high, start bit is low. Already synchronized to `clk` by the parent.
- `Btu`  input  1  bit-time-up pulse from the bit-time counter. While `Start`=1 it marks half a bit time; otherwise it marks a full bit time.
- `Done`  input  1  bit counter has counted the full frame (start + data + parity/stop).
- `DoIt`  output  1  enables the bit-time counter and bit counter; 1 while a frame is being checked or received.
- `Start`  output  1  selects the half-bit-time count in the bit-time counter; 1 only while the start bit is being verified.

## Operation
- State register is 2 bits with these encodings:
  - IDLE = 2'b00
  - START = 2'b01
  - RECEIVE = 2'b10
  - 2'b11 is illegal.
- Outputs are a Moore decode of the state register, with no combinational path from the inputs:
  - IDLE: `Start`=0, `DoIt`=0.
  - START: `Start`=1, `DoIt`=1.
  - RECEIVE: `Start`=0, `DoIt`=1.
  - Illegal (2'b11): `Start`=0, `DoIt`=0.
- Transitions, evaluated in priority order within each state:
  - IDLE: `Rx`=0 → START; otherwise stay in IDLE.
  - START: `Rx`=1 → IDLE (false start or glitch; this takes priority over `Btu`). `Rx`=0 and `Btu`=1 → RECEIVE. Otherwise stay in START.
  - RECEIVE: `Done`=1 → IDLE; otherwise stay in RECEIVE. `Rx` and `Btu` are ignored here, because bit sampling belongs to the datapath.
  - Illegal state 2'b11: go to IDLE unconditionally.
- `Done` is ignored in IDLE and START. `Btu` is ignored in IDLE.
- `reset`=1 at a rising edge forces IDLE regardless of current state or inputs, so both outputs are 0 after that edge. Reset during RECEIVE aborts the frame.

## Timing
- Latency from input to output is one clock: an input sampled at edge k changes the outputs just after edge k.
- `Rx` falling while in IDLE sets `Start`=1 and `DoIt`=1 on the next edge.
- `Btu`=1 with `Rx`=0 in START sets `Start`=0 on the next edge; `DoIt` stays 1 without a gap.
- `Done`=1 in RECEIVE drops `DoIt` to 0 on the next edge.
- A frame can restart immediately. If `Rx`=0 on the edge after the return to IDLE, START is entered on that edge.
- Signals are levels, not pulses. A `Btu` held high across several cycles in START causes exactly one transition. `Done` held high causes a single return to IDLE.
- Reset values: `Start`=0, `DoIt`=0, state=IDLE.

## Test plan
- Reset: assert `reset` for 10 clocks with `Rx`=0 → `Start`=0 and `DoIt`=0 throughout. Release with `Rx`=1 and hold for 50 clocks → outputs stay 0.
- Start detect: from IDLE drive `Rx`=0 with `Btu`=0 for 50 clocks → one edge later `Start`=1, `DoIt`=1, and they hold for all 50 clocks.
- Start confirm: in START set `Btu`=1 with `Rx`=0 → next edge `Start`=0, `DoIt`=1. With `Done`=0 the block stays in RECEIVE for 60 clocks regardless of `Rx`/`Btu`.
- False start: in START raise `Rx`=1 with `Btu`=0, then separately repeat with `Btu`=1 in the same cycle → next edge both outputs are 0 (IDLE) in both cases.
- Frame end: in RECEIVE pulse `Done`=1 for one clock → next edge `DoIt`=0. With `Rx`=0 held, the edge after that gives `Start`=1, `DoIt`=1 (back-to-back frame).
- Reset mid-frame: in RECEIVE assert `reset` for one clock with `Done`=0 and `Rx`=0 → `DoIt`=0 and `Start`=0 after that edge, then START is entered on the following edge.
